tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_pkg.sv | 16 +
 rtl/tt_settle_timer.sv | 30 +++
 rtl/tt_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned TT_W   = 16;
  localparam int unsigned ONES_W = 5;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle countdown: loadable down-counter with a zero flag.
module tt_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps a 4-input combinational function over all minterms and captures
// its truth table, 1-count and a comparison against a golden table.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned N_IN   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [tt_sweep_pkg::TT_W-1:0] expect_tt,
  output logic [N_IN-1:0]               x,
  input  logic                          y,
  output logic                          busy,
  output logic [tt_sweep_pkg::TT_W-1:0] tt,
  output logic [tt_sweep_pkg::ONES_W-1:0] ones,
  output logic                          mismatch,
  output logic                          tt_valid,
  input  logic                          tt_ready
);

  import tt_sweep_pkg::*;

  localparam logic [CNT_W-1:0] LOAD_VAL = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  IDX_LAST = '1;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     idx_q;
  logic [TT_W-1:0]     tt_q, tt_nxt, exp_q;
  logic [ONES_W-1:0]   ones_q;
  logic                mismatch_q;

  logic                accept, sample, tmr_load, tmr_dec, tmr_clr, tmr_zero;

  tt_settle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort is checked first in every active state so it outranks both
  // sampling and the DONE handshake.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    sample   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          accept   = 1'b1;
          tmr_load = (SETTLE != 0);
          state_d  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          tmr_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sample = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else if (SETTLE != 0) begin
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        if (abort || tt_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tt_nxt        = tt_q;
    tt_nxt[idx_q] = y;
  end

  // x is the minterm index itself; it holds at 15 once the sweep completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      tt_q       <= '0;
      exp_q      <= '0;
      ones_q     <= '0;
      mismatch_q <= 1'b0;
    end else if (accept) begin
      idx_q      <= '0;
      tt_q       <= '0;
      exp_q      <= expect_tt;
      ones_q     <= '0;
      mismatch_q <= 1'b0;
    end else if (sample) begin
      tt_q   <= tt_nxt;
      ones_q <= ones_q + ONES_W'(y);
      if (idx_q != IDX_LAST) begin
        idx_q <= idx_q + 1'b1;
      end else begin
        mismatch_q <= (tt_nxt != exp_q);
      end
    end
  end

  assign x        = idx_q;
  assign tt       = tt_q;
  assign ones     = ones_q;
  assign mismatch = mismatch_q;
  assign busy     = (state_q != ST_IDLE);
  assign tt_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: three instances with SETTLE=1/0/3.
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;

  logic        start1 = 1'b0, start0 = 1'b0, start3 = 1'b0;
  logic [15:0] exp1 = '0, exp0 = '0, exp3 = '0;
  logic [3:0]  x1, x0, x3;
  logic        y1, y0, y3;
  logic        busy1, busy0, busy3;
  logic [15:0] tt1, tt0, tt3;
  logic [4:0]  ones1, ones0, ones3;
  logic        mis1, mis0, mis3;
  logic        val1, val0, val3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y1 = x1[0] & x1[1];
  assign y0 = ^x0;
  assign y3 = 1'b1;

  tt_sweep_ctrl #(.SETTLE(1), .N_IN(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .expect_tt(exp1),
    .x(x1), .y(y1), .busy(busy1), .tt(tt1), .ones(ones1), .mismatch(mis1),
    .tt_valid(val1), .tt_ready(ready));

  tt_sweep_ctrl #(.SETTLE(0), .N_IN(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .expect_tt(exp0),
    .x(x0), .y(y0), .busy(busy0), .tt(tt0), .ones(ones0), .mismatch(mis0),
    .tt_valid(val0), .tt_ready(ready));

  tt_sweep_ctrl #(.SETTLE(3), .N_IN(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .expect_tt(exp3),
    .x(x3), .y(y3), .busy(busy3), .tt(tt3), .ones(ones3), .mismatch(mis3),
    .tt_valid(val3), .tt_ready(ready));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic valid_of(input int which);
    case (which)
      1:       return val1;
      0:       return val0;
      default: return val3;
    endcase
  endfunction

  // Counts edges after the acceptance edge until tt_valid rises (0 = timeout).
  task automatic wait_valid(input int which, output int lat);
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (valid_of(which) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int rises;
    bit found;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_x",     32'(x1),    32'h0);
    check("rst_tt",    32'(tt1),   32'h0);
    check("rst_ones",  32'(ones1), 32'h0);
    check("rst_valid", 32'(val1),  32'h0);
    check("rst_busy",  32'(busy1), 32'h0);
    check("rst_mis",   32'(mis1),  32'h0);
    rst_n = 1'b1;

    // SETTLE=1, y=x0&x1; expect_tt changed mid-sweep must be ignored
    @(negedge clk); exp1 = 16'h8888; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0; exp1 = 16'h1234;
    check("s1_busy_start", 32'(busy1), 32'h1);
    check("s1_x_start",    32'(x1),    32'h0);
    wait_valid(1, lat);
    check("s1_latency", 32'(lat),   32'd32);
    check("s1_tt",      32'(tt1),   32'h8888);
    check("s1_ones",    32'(ones1), 32'd4);
    check("s1_mis",     32'(mis1),  32'h0);
    check("s1_x_hold",  32'(x1),    32'hF);

    // Hold in DONE for 10 cycles with a stray start
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start1 = (i == 4);
      @(posedge clk); #1;
      if (val1 !== 1'b1 || tt1 !== 16'h8888 || ones1 !== 5'd4 || mis1 !== 1'b0) bad++;
    end
    start1 = 1'b0;
    check("done_stable", 32'(bad), 32'h0);
    handshake();
    check("hs_valid", 32'(val1), 32'h0);
    check("hs_busy",  32'(busy1), 32'h0);
    check("hs_tt_kept", 32'(tt1), 32'h8888);
    repeat (3) @(posedge clk);
    #1;
    check("hs_stays_idle", 32'(busy1), 32'h0);

    // SETTLE=0, parity function
    @(negedge clk); exp0 = 16'h0000; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    wait_valid(0, lat);
    check("s0_latency", 32'(lat),   32'd16);
    check("s0_tt",      32'(tt0),   32'h6996);
    check("s0_ones",    32'(ones0), 32'd8);
    check("s0_mis",     32'(mis0),  32'h1);
    handshake();
    check("s0_valid_drop", 32'(val0), 32'h0);
    check("s0_mis_kept",   32'(mis0), 32'h1);

    // SETTLE=3, y=1; x must hold each value for 4 cycles
    @(negedge clk); exp3 = 16'hFFFF; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    bad = (x3 !== 4'd0) ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (x3 !== 4'((k / 4 > 15) ? 15 : k / 4)) bad++;
      if (val3 === 1'b1 && lat == 0) lat = k;
    end
    check("s3_x_steps", 32'(bad),   32'h0);
    check("s3_latency", 32'(lat),   32'd64);
    check("s3_tt",      32'(tt3),   32'hFFFF);
    check("s3_ones",    32'(ones3), 32'd16);
    check("s3_mis",     32'(mis3),  32'h0);
    handshake();

    // Start and abort together in IDLE: abort wins
    @(negedge clk); start1 = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start1 = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy1), 32'h0);

    // Abort at minterm 7
    @(negedge clk); exp1 = 16'h8888; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (x1 === 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach_x7", 32'(found), 32'h1);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy",   32'(busy1), 32'h0);
    check("abort_valid",  32'(val1),  32'h0);
    check("abort_tt",     32'(tt1),   32'h0008);
    check("abort_tt_hi",  32'(tt1[15:8]), 32'h0);
    check("abort_ones",   32'(ones1), 32'd1);
    rises = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (val1 !== 1'b0) rises++;
    end
    check("abort_no_valid", 32'(rises), 32'h0);

    // Asynchronous reset mid-sweep
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    check("pre_rst_tt", 32'(tt1), 32'h0008);
    rst_n = 1'b0;
    #1;
    check("arst_x",     32'(x1),    32'h0);
    check("arst_tt",    32'(tt1),   32'h0);
    check("arst_ones",  32'(ones1), 32'h0);
    check("arst_busy",  32'(busy1), 32'h0);
    check("arst_valid", 32'(val1),  32'h0);
    check("arst_tt0",   32'(tt0),   32'h0);
    check("arst_mis0",  32'(mis0),  32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Fresh sweep after reset
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    check("fresh_x", 32'(x1), 32'h0);
    wait_valid(1, lat);
    check("fresh_latency", 32'(lat), 32'd32);
    check("fresh_tt",      32'(tt1), 32'h8888);
    check("fresh_mis",     32'(mis1), 32'h0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
